// File: rtl/adrv9001_tdd_sched.sv
// ============================================================================
// adrv9001_tdd_sched: repeating TDD frame timeline driving rx1/rx2/tx1/tx2 enables
// Rev 1.0
// ============================================================================
`default_nettype none

module adrv9001_tdd_sched #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter bit MUTEX  = 1'b1
) (
  input  logic                    s_axi_aclk,
  input  logic                    s_axi_aresetn,
  input  logic                    start,
  input  logic                    stop,
  input  logic [CNT_W-1:0]        frame_len,
  input  logic [15:0]             num_frames,
  input  logic [NUM_CH*CNT_W-1:0] ch_on,
  input  logic [NUM_CH*CNT_W-1:0] ch_off,
  output logic [NUM_CH-1:0]       en,
  output logic                    busy,
  output logic                    frame_strobe,
  output logic                    done,
  output logic [15:0]             frame_idx,
  output logic                    conflict
);

  localparam int HALF = NUM_CH / 2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_LAST = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d;
  logic [CNT_W-1:0]        len_q, len_d;
  logic [NUM_CH*CNT_W-1:0] on_q, on_d;
  logic [NUM_CH*CNT_W-1:0] off_q, off_d;
  logic [15:0]             num_q, num_d;
  logic [15:0]             idx_q, idx_d;
  logic                    stop_q, stop_d;
  logic [NUM_CH-1:0]       en_q, en_d;
  logic                    strobe_q, strobe_d;
  logic                    done_q, done_d;
  logic                    conflict_q, conflict_d;

  logic [NUM_CH-1:0]       win;
  logic [NUM_CH-1:0]       win_mx;
  logic [NUM_CH-1:0]       clash;
  logic                    last_cyc;
  logic                    end_run;

  // Window evaluation against the shadowed offsets of the current frame.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_win
    logic [CNT_W-1:0] on_k;
    logic [CNT_W-1:0] off_k;
    assign on_k   = on_q[k*CNT_W +: CNT_W];
    assign off_k  = off_q[k*CNT_W +: CNT_W];
    assign win[k] = (on_k < off_k) ? ((cnt_q >= on_k) && (cnt_q < off_k)) :
                    (on_k > off_k) ? ((cnt_q >= on_k) || (cnt_q < off_k)) :
                    1'b0;
  end

  // RX has priority: a TX window overlapping its paired RX window is masked.
  for (genvar k = 0; k < NUM_CH; k++) begin : g_mx
    if (MUTEX && (k >= HALF) && (k < 2 * HALF)) begin : g_pair
      assign win_mx[k] = win[k] & ~win[k-HALF];
      assign clash[k]  = win[k] &  win[k-HALF];
    end else begin : g_solo
      assign win_mx[k] = win[k];
      assign clash[k]  = 1'b0;
    end
  end

  assign last_cyc = (cnt_q == len_q - CNT_W'(1));
  assign end_run  = stop_q || stop ||
                    ((num_q != 16'd0) && (({1'b0, idx_q} + 17'd1) == {1'b0, num_q}));

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    len_d      = len_q;
    on_d       = on_q;
    off_d      = off_q;
    num_d      = num_q;
    idx_d      = idx_q;
    stop_d     = stop_q;
    en_d       = '0;
    strobe_d   = 1'b0;
    done_d     = 1'b0;
    conflict_d = conflict_q;
    case (state_q)
      S_IDLE: begin
        if (start && !stop && (frame_len >= CNT_W'(2))) begin
          state_d    = S_RUN;
          cnt_d      = '0;
          idx_d      = '0;
          conflict_d = 1'b0;
          stop_d     = 1'b0;
          len_d      = frame_len;
          on_d       = ch_on;
          off_d      = ch_off;
          num_d      = num_frames;
          strobe_d   = 1'b1;
        end
      end
      S_RUN: begin
        en_d = win_mx;
        if (|clash) conflict_d = 1'b1;
        if (stop)   stop_d     = 1'b1;
        if (last_cyc) begin
          cnt_d = '0;
          idx_d = (idx_q == 16'hFFFF) ? idx_q : idx_q + 16'd1;
          if (end_run) begin
            state_d = S_LAST;
          end else begin
            len_d    = frame_len;
            on_d     = ch_on;
            off_d    = ch_off;
            strobe_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      S_LAST: begin
        state_d = S_IDLE;
        stop_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge s_axi_aclk or negedge s_axi_aresetn) begin
    if (!s_axi_aresetn) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      len_q      <= '0;
      on_q       <= '0;
      off_q      <= '0;
      num_q      <= '0;
      idx_q      <= '0;
      stop_q     <= 1'b0;
      en_q       <= '0;
      strobe_q   <= 1'b0;
      done_q     <= 1'b0;
      conflict_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      len_q      <= len_d;
      on_q       <= on_d;
      off_q      <= off_d;
      num_q      <= num_d;
      idx_q      <= idx_d;
      stop_q     <= stop_d;
      en_q       <= en_d;
      strobe_q   <= strobe_d;
      done_q     <= done_d;
      conflict_q <= conflict_d;
    end
  end

  assign en           = en_q;
  assign busy         = (state_q != S_IDLE);
  assign frame_strobe = strobe_q;
  assign done         = done_q;
  assign frame_idx    = idx_q;
  assign conflict     = conflict_q;

endmodule

`default_nettype wire

// File: tb/tb_adrv9001_tdd_sched.sv
// Bench for adrv9001_tdd_sched: directed timeline scenarios plus randomized traffic
// checked every cycle against a frame-level reference model.
`default_nettype none

module tb_adrv9001_tdd_sched;

  localparam int NUM_CH = 4;
  localparam int CNT_W  = 32;

  logic                    clk = 1'b0;
  logic                    rst_n;
  logic                    start;
  logic                    stop;
  logic [CNT_W-1:0]        frame_len;
  logic [15:0]             num_frames;
  logic [NUM_CH*CNT_W-1:0] ch_on;
  logic [NUM_CH*CNT_W-1:0] ch_off;
  logic [NUM_CH-1:0]       en;
  logic                    busy;
  logic                    frame_strobe;
  logic                    done;
  logic [15:0]             frame_idx;
  logic                    conflict;

  int checks = 0;
  int errors = 0;

  adrv9001_tdd_sched #(.NUM_CH(NUM_CH), .CNT_W(CNT_W), .MUTEX(1'b1)) dut (
    .s_axi_aclk   (clk),
    .s_axi_aresetn(rst_n),
    .start        (start),
    .stop         (stop),
    .frame_len    (frame_len),
    .num_frames   (num_frames),
    .ch_on        (ch_on),
    .ch_off       (ch_off),
    .en           (en),
    .busy         (busy),
    .frame_strobe (frame_strobe),
    .done         (done),
    .frame_idx    (frame_idx),
    .conflict     (conflict)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model: frame-level rules ----------------
  int unsigned m_len, m_cnt, m_on[NUM_CH], m_off[NUM_CH];
  int          m_num, m_idx;
  bit          m_busy, m_ending, m_pend, m_conf, m_strobe, m_done;
  logic [NUM_CH-1:0] m_en;

  function automatic bit in_win(input int unsigned c, input int unsigned on, input int unsigned off);
    if (on < off) return (c >= on) && (c < off);
    if (on > off) return (c >= on) || (c < off);
    return 1'b0;
  endfunction

  function automatic void load_frame_cfg();
    m_len = frame_len;
    for (int k = 0; k < NUM_CH; k++) begin
      m_on[k]  = ch_on[k*CNT_W +: CNT_W];
      m_off[k] = ch_off[k*CNT_W +: CNT_W];
    end
  endfunction

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_busy = 0; m_ending = 0; m_pend = 0; m_conf = 0; m_strobe = 0; m_done = 0;
        m_cnt = 0; m_idx = 0; m_en = '0;
      end else begin
        m_strobe = 0;
        m_done   = 0;
        if (!m_busy) begin
          m_en = '0;
          if (start && !stop && frame_len >= 2) begin
            m_busy = 1; m_cnt = 0; m_idx = 0; m_conf = 0; m_pend = 0;
            m_num = num_frames;
            load_frame_cfg();
            m_strobe = 1;
          end
        end else if (m_ending) begin
          m_busy = 0; m_ending = 0; m_done = 1; m_en = '0;
        end else begin
          for (int k = 0; k < NUM_CH/2; k++) begin
            bit rx, tx;
            rx = in_win(m_cnt, m_on[k], m_off[k]);
            tx = in_win(m_cnt, m_on[k+2], m_off[k+2]);
            m_en[k]   = rx;
            m_en[k+2] = tx && !rx;
            if (rx && tx) m_conf = 1;
          end
          if (stop) m_pend = 1;
          if (m_cnt + 1 == m_len) begin
            if (m_idx < 65535) m_idx++;
            m_cnt = 0;
            if (m_pend || (m_num != 0 && m_idx == m_num)) m_ending = 1;
            else begin
              load_frame_cfg();
              m_strobe = 1;
            end
          end else begin
            m_cnt++;
          end
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n)
        chk("cycle", {8'd0, en, busy, frame_strobe, done, frame_idx, conflict},
                     {8'd0, m_en, m_busy, m_strobe, m_done, 16'(m_idx), m_conf});
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input int unsigned on, input int unsigned off);
    ch_on[k*CNT_W +: CNT_W]  = on;
    ch_off[k*CNT_W +: CNT_W] = off;
  endtask

  task automatic cfg_clear();
    ch_on = '0; ch_off = '0; frame_len = 10; num_frames = 1; start = 0; stop = 0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 200) begin
      tick();
      n++;
    end
    chk(name, busy, 0);
  endtask

  // Single frame: window [2,5) in a 10-clock frame, start sampled at T0.
  task automatic run_single(input string tag);
    cfg_clear();
    set_ch(0, 2, 5);
    start = 1; tick(); start = 0;
    for (int i = 1; i <= 13; i++) begin
      chk({tag, "_en0"},  en[0], (i >= 4 && i <= 6));
      chk({tag, "_done"}, done,  (i == 12));
      chk({tag, "_busy"}, busy,  (i <= 11));
      if (i == 1)  chk({tag, "_strobe"}, frame_strobe, 1);
      if (i == 12) chk({tag, "_idx"},    frame_idx,    1);
      tick();
    end
  endtask

  initial begin
    int cnt_a, cnt_b, cur, maxr, done_at, done_n, idx_at;
    rst_n = 0;
    cfg_clear();
    repeat (3) tick();
    chk("reset_outs", {en, busy, frame_strobe, done, frame_idx, conflict}, 0);
    rst_n = 1;
    tick();
    chk("post_reset_outs", {en, busy, frame_strobe, done, frame_idx, conflict}, 0);

    run_single("single");

    // Wrapped window: cnt 6,7,0,1 each frame, 2 frames.
    wait_idle("idle_wrap");
    cfg_clear(); frame_len = 8; num_frames = 2; set_ch(2, 6, 2);
    start = 1; tick(); start = 0;
    cnt_a = 0; cur = 0; maxr = 0; done_at = 0;
    for (int i = 1; i <= 20; i++) begin
      if (en[2]) begin cnt_a++; cur++; end else cur = 0;
      if (cur > maxr) maxr = cur;
      if (done) done_at = i;
      tick();
    end
    chk("wrap_total", cnt_a, 8);
    chk("wrap_maxrun", maxr, 4);
    chk("wrap_done_at", done_at, 18);

    // Exclusion: rx1 [1,6) vs tx1 [4,9).
    cfg_clear(); set_ch(0, 1, 6); set_ch(2, 4, 9);
    start = 1; tick(); start = 0;
    cnt_a = 0; cnt_b = 0; done_at = 0;
    for (int i = 1; i <= 13; i++) begin
      if (en[0]) cnt_a++;
      if (en[2]) begin
        cnt_b++;
        if (cnt_b == 1) chk("mutex_tx_first", i, 8);
      end
      tick();
    end
    chk("mutex_rx_count", cnt_a, 5);
    chk("mutex_tx_count", cnt_b, 3);
    chk("mutex_conflict", conflict, 1);

    // Continuous run, stop at cnt=1 of frame 3 (frames counted from 0).
    cfg_clear(); frame_len = 5; num_frames = 0; set_ch(1, 0, 3);
    start = 1; tick(); start = 0;
    done_n = 0; done_at = 0; idx_at = 0;
    for (int i = 1; i <= 26; i++) begin
      if (done) begin done_n++; done_at = i; idx_at = frame_idx; end
      stop = (i == 17);
      tick();
    end
    stop = 0;
    chk("cont_done_count", done_n, 1);
    chk("cont_done_at", done_at, 22);
    chk("cont_idx", idx_at, 4);
    chk("cont_conflict_cleared", conflict, 0);

    // start+stop together in IDLE.
    cfg_clear();
    start = 1; stop = 1; tick(); start = 0; stop = 0;
    chk("startstop_busy", busy, 0);
    tick();
    chk("startstop_busy2", busy, 0);

    // frame_len < 2 ignored.
    frame_len = 1;
    start = 1; tick(); start = 0;
    chk("len1_busy", busy, 0);

    // start while busy: no restart.
    cfg_clear(); set_ch(0, 2, 5);
    start = 1; tick(); start = 0;
    done_at = 0;
    for (int i = 1; i <= 14; i++) begin
      if (done) begin done_at = i; chk("rebusy_idx", frame_idx, 1); end
      start = (i == 4);
      tick();
    end
    start = 0;
    chk("rebusy_done_at", done_at, 12);

    // Reset mid-run at cnt=3.
    cfg_clear(); num_frames = 2; set_ch(0, 0, 8);
    start = 1; tick(); start = 0;
    repeat (3) tick();
    chk("pre_reset_en0", en[0], 1);
    rst_n = 0;
    #1;
    chk("async_reset_outs", {en, busy, frame_strobe, done, frame_idx, conflict}, 0);
    tick();
    rst_n = 1;
    done_n = 0;
    for (int i = 0; i < 6; i++) begin
      if (done || busy) done_n++;
      tick();
    end
    chk("post_reset_quiet", done_n, 0);
    run_single("after_reset");

    // Randomized traffic, checked cycle by cycle against the model.
    for (int n = 0; n < 4000; n++) begin
      start = ($urandom_range(0, 9) == 0);
      stop  = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 7) == 0) begin
        frame_len  = $urandom_range(2, 12);
        num_frames = 16'($urandom_range(0, 3));
        for (int k = 0; k < NUM_CH; k++)
          set_ch(k, $urandom_range(0, 14), $urandom_range(0, 14));
      end
      if ($urandom_range(0, 399) == 0) begin
        rst_n = 0;
        tick();
        rst_n = 1;
      end
      tick();
    end
    start = 0;
    stop  = 1; tick(); stop = 0;
    wait_idle("final_idle");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/adrv9001_tdd_sched.md
# adrv9001_tdd_sched

TDD frame scheduler that drives the ADRV9001 channel enables (rx1, rx2, tx1, tx2) from a programmable, repeating frame timeline. A free-running frame counter is compared against per-channel on/off offsets to produce registered enable windows. The block enforces RX/TX mutual exclusion per channel pair and supports a finite frame count or continuous operation. It sits between the register block, which supplies the timeline configuration and start/stop, and the rx/tx channel modules, which consume the enables as their `enable`/`tdd_en` sources.

## Interface
- NUM_CH, 4, number of scheduled enables; bit order rx1, rx2, tx1, tx2.
- CNT_W, 32, width of frame counter and offsets.
- MUTEX, 1, when 1, enforce exclusion on pairs (0,2) and (1,3).
- s_axi_aclk  in  1  single clock; all logic is on its rising edge.
- s_axi_aresetn  in  1  asynchronous, active-low reset.
- start  in  1  single-cycle pulse; begins a run from IDLE.
- stop  in  1  single-cycle pulse; requests end of run at the next frame boundary.
- frame_len  in  CNT_W  frame length in clocks; valid range ≥ 2.
- num_frames  in  16  frames per run; 0 means continuous.
- ch_on  in  NUM_CH*CNT_W  per-channel enable offset; channel k at [k*CNT_W +: CNT_W].
- ch_off  in  NUM_CH*CNT_W  per-channel disable offset, same packing.
- en  out  NUM_CH  registered channel enables.
- busy  out  1  high while not IDLE.
- frame_strobe  out  1  one-cycle pulse when the counter is 0.
- done  out  1  one-cycle pulse on return to IDLE.
- frame_idx  out  16  count of completed frames in the current run.
- conflict  out  1  sticky flag: an exclusion override occurred; cleared by start.

## Operation
- States are IDLE, RUN, and LAST.
  - IDLE→RUN: start=1 and frame_len≥2. If frame_len<2, start is ignored.
  - RUN→LAST: a stop is latched, or frame_idx+1 == num_frames while num_frames≠0. The transition happens when cnt == frame_len-1.
  - LAST→IDLE: one cycle later. done pulses and en is cleared.
- start while busy is ignored.
- start and stop together in IDLE: stop wins and the block stays IDLE.
- A stop pulse in RUN is latched until it is honored.
- Shadow registers capture frame_len, ch_on, ch_off and num_frames on start.
  - frame_len, ch_on and ch_off are recaptured each time cnt wraps to 0.
  - num_frames is fixed for the run.
  - Config changes mid-frame have no effect until the next frame.
- Frame counter cnt is 0 on the first RUN cycle. It increments by 1 and wraps to 0 after frame_len-1, incrementing frame_idx (saturating at 0xFFFF).
- Window for channel k (unsigned compares):
  - on<off: active when on ≤ cnt < off.
  - on>off: active when cnt ≥ on or cnt < off (the window wraps across the frame boundary).
  - on==off: never active.
  - Offsets ≥ frame_len are never reached. The wrapped case then reduces to cnt < off.
- Exclusion (MUTEX=1): if rx_k and tx_k windows are both active, tx_k is forced 0, rx_k is unaffected, and conflict is set.
- start clears frame_idx, conflict and cnt.

## Timing
- Reset values: en=0, busy=0, frame_strobe=0, done=0, frame_idx=0, conflict=0, state=IDLE, cnt=0.
- start is sampled at edge T0. busy=1 and cnt=0 at T0+1, with frame_strobe=1 in the same cycle.
- en has one cycle of latency: en[k] at cycle t reflects the window evaluated on cnt at t-1. The first en can therefore assert at T0+2 when on=0.
- Enable pulse width is exactly off-on clocks (non-wrapped case). Wrapped width is frame_len-on+off.
- Final frame: cnt reaches frame_len-1 at cycle F.
  - LAST occurs at F+1, with en still reflecting cnt=frame_len-1.
  - At F+2: IDLE, busy=0, en=0, done=1 for one cycle.
- Asynchronous reset mid-run forces all outputs to their reset values immediately. No done pulse is produced.

## Test plan
- **Single frame:** frame_len=10, num_frames=1, ch_on[0]=2, ch_off[0]=5, start at T0. Expect en[0] high during T0+4..T0+6 (3 clocks), done=1 at T0+12, frame_idx=1.
- **Wrap window:** frame_len=8, ch_on[2]=6, ch_off[2]=2, num_frames=2. Expect en[2] high 4 clocks per frame, continuous across the frame boundary.
- **Exclusion:** ch0 window [1,6), ch2 window [4,9), frame_len=10. Expect en[2] high only for cnt 6..8, en[0] unaffected, conflict=1.
- **Continuous with stop:** num_frames=0, frame_len=5, stop at cnt=1 of frame 3. Expect run to end after cnt=4 of that frame, done once, frame_idx=4.
- **Start/stop edge cases:** start and stop together in IDLE → busy stays 0. start with frame_len=1 → ignored. start while busy → no restart (cnt continues).
- **Reset mid-run:** assert s_axi_aresetn=0 at cnt=3. Expect en=0 and busy=0 immediately, no done. After release, a new start runs normally.
